// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit producing the architectural HI/LO pair.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rstn   - asynchronous active-low reset
//   Start  - operation request, accepted only while Busy=0
//   MDUOp  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   A, B   - operands (rs, rt), latched on the accepting edge
//   Busy   - a multiply or divide is in flight
//   Done   - one-cycle pulse in the cycle HI/LO first shows a mult/div result
//   HI, LO - architectural HI/LO registers
//
// Multiply latency is MULT_LAT edges; divide latency is 34 edges
// (setup, 32 restoring iterations, sign fixup). HI/LO change only on the
// completion edge, so partial results are never visible.
module mdu #(
  parameter int MULT_LAT = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int DATA_W = 32;
  localparam int MCNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MBUSY  = 3'd1,
    S_DSETUP = 3'd2,
    S_DITER  = 3'd3,
    S_DFIX   = 3'd4
  } state_t;

  // Two's-complement magnitude when the value is treated as signed.
  function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] x,
                                              input logic             is_signed);
    f_mag = (is_signed && x[DATA_W-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [DATA_W-1:0] f_cneg(input logic [DATA_W-1:0] x,
                                               input logic             neg);
    f_cneg = neg ? (~x + 1'b1) : x;
  endfunction

  state_t              r_state, w_next;
  logic [MCNT_W-1:0]   r_mcnt;
  logic [5:0]          r_icnt;
  logic                r_done;
  logic [DATA_W-1:0]   r_hi, r_lo;

  // Operand / datapath registers (no reset: qualified by the FSM state).
  logic [DATA_W-1:0]   r_a, r_b;
  logic                r_sgn;
  logic [DATA_W-1:0]   r_dvd, r_dvs;
  logic                r_neg_q, r_neg_r, r_dvz;
  logic [DATA_W-1:0]   r_rem, r_quo;

  logic                w_accept;
  logic                w_mthi, w_mtlo;
  logic                w_mul_wr, w_div_wr;
  logic signed [63:0]  w_ma, w_mb, w_prod;
  logic [DATA_W:0]     w_rem_sh, w_diff;
  logic                w_div_signed;

  assign w_accept     = Start && (r_state == S_IDLE);
  assign w_div_signed = (MDUOp == 3'b010);

  // ---- state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // ---- next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (MDUOp)
            3'b000, 3'b001: w_next = S_MBUSY;
            3'b010, 3'b011: w_next = S_DSETUP;
            default:        w_next = S_IDLE;
          endcase
        end
      end
      S_MBUSY:  if (r_mcnt == '0) w_next = S_IDLE;
      S_DSETUP: w_next = S_DITER;
      S_DITER:  if (r_icnt == 6'd31) w_next = S_DFIX;
      S_DFIX:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // ---- output / control decode
  always_comb begin
    Busy     = (r_state != S_IDLE);
    w_mthi   = w_accept && (MDUOp == 3'b100);
    w_mtlo   = w_accept && (MDUOp == 3'b101);
    w_mul_wr = (r_state == S_MBUSY) && (r_mcnt == '0);
    w_div_wr = (r_state == S_DFIX);
  end

  // Low 64 bits of the product are identical for signed and unsigned once
  // the operands are extended according to the latched signedness.
  assign w_ma   = {{32{r_sgn & r_a[DATA_W-1]}}, r_a};
  assign w_mb   = {{32{r_sgn & r_b[DATA_W-1]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // 33-bit trial subtract: the shifted partial remainder is below 2*divisor,
  // so bit 32 of the difference is a reliable borrow flag.
  assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};

  // ---- control counters, Done and architectural HI/LO
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mcnt <= '0;
      r_icnt <= '0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= w_mul_wr | w_div_wr;

      if (w_accept)                                r_mcnt <= MCNT_W'(MULT_LAT - 1);
      else if (r_state == S_MBUSY && r_mcnt != '0) r_mcnt <= r_mcnt - 1'b1;

      if (r_state == S_DSETUP)     r_icnt <= '0;
      else if (r_state == S_DITER) r_icnt <= r_icnt + 1'b1;

      if (w_mthi) r_hi <= A;
      if (w_mtlo) r_lo <= A;

      if (w_mul_wr) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end

      if (w_div_wr) begin
        if (r_dvz) begin
          r_hi <= r_a;
          r_lo <= '1;
        end else begin
          r_hi <= f_cneg(r_rem, r_neg_r);
          r_lo <= f_cneg(r_quo, r_neg_q);
        end
      end
    end
  end

  // ---- operand latch and restoring-division datapath
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_sgn   <= (MDUOp == 3'b000);
      r_dvd   <= f_mag(A, w_div_signed);
      r_dvs   <= f_mag(B, w_div_signed);
      r_neg_q <= w_div_signed && (A[DATA_W-1] ^ B[DATA_W-1]);
      r_neg_r <= w_div_signed && A[DATA_W-1];
      r_dvz   <= (B == '0);
    end

    if (r_state == S_DSETUP) begin
      r_rem <= '0;
      r_quo <= r_dvd;
    end else if (r_state == S_DITER) begin
      if (!w_diff[DATA_W]) begin
        r_rem <= w_diff[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
      end else begin
        r_rem <= w_rem_sh[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
